cook_timer: RTL
===============

// Module: cook_timer
// PURPOSE
//  Countdown cook timer producing timer_done for magnetron_control, and consuming its mag_on.
//  Holds an MM:SS BCD cook time entered digit-by-digit from the keypad.
//  Decrements once per second while mag_on is high. Pauses, keeping the partial second, when mag_on drops.
//  Emits a one-cycle timer_done pulse when the count reaches 00:00.
// PARAMETERS
//  TICKS_PER_SEC  100  clk cycles per second of cook time; must be >= 2
// PORTS
//  clk          in   1   system clock, rising edge
//  reset_       in   1   asynchronous reset, active low
//  digit_valid  in   1   one-cycle strobe: digit holds a keypad entry
//  digit        in   4   keypad digit; only 0..9 are legal
//  clear_       in   1   clear request, active low, sampled on clk
//  mag_on       in   1   magnetron enable from magnetron_control
//  time_bcd     out  16  {m10,m1,s10,s1} BCD remaining/programmed time
//  running      out  1   high while state==RUN
//  timer_done   out  1   one-cycle pulse on reaching 00:00
// BEHAVIOUR
//  - Reset (async, reset_=0):
//    - state=IDLE, time_bcd=0, prescaler=0, running=0, timer_done=0.
//  - FSM states: IDLE, RUN, PAUSED, DONE. All outputs are registered.
//  - clear_=0 at a clk edge, from any state:
//    - state=IDLE, time_bcd=0, prescaler=0, timer_done=0.
//    - Beats every other event in the same cycle.
//  - IDLE, digit_valid=1, digit<=9:
//    - time_bcd <= {time_bcd[11:0],digit}; old m10 is discarded.
//    - digit>9 is ignored.
//    - digit_valid is ignored in RUN, PAUSED and DONE.
//  - IDLE transitions:
//    - mag_on=1 & time_bcd!=0 -> RUN, prescaler=0.
//    - mag_on=1 & time_bcd==0 -> stay IDLE, no pulse.
//  - RUN, mag_on=1: prescaler increments.
//    - At TICKS_PER_SEC-1 the prescaler wraps to 0 and time_bcd decrements by one second.
//    - If the decrement gives 0000 -> DONE.
//  - RUN, mag_on=0 -> PAUSED. prescaler and time_bcd are held.
//  - PAUSED transitions:
//    - mag_on=1 -> RUN; prescaler resumes from its held value.
//    - clear_ -> IDLE.
//  - DONE: timer_done=1 for exactly this one cycle, then -> IDLE (time_bcd=0).
//  - BCD decrement, with borrow:
//    - s1: 0->9 borrows from s10.
//    - s10: 0->5 borrows from m1.
//    - m1: 0->9 borrows from m10.
//    - Entered seconds above 59 (e.g. 0:90) are legal and count down naturally: 0:90 -> 0:89 ... 0:00.
//  - Tick and mag_on falling in the same cycle: mag_on=0 is sampled, so no decrement occurs.
//  - running = (state==RUN). timer_done=0 in every state except DONE.
// STRUCTURE
//  - cook_timer_defs.vh holds:
//    - state encodings IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, DONE=2'd3;
//    - BCD_MAX_UNIT=4'd9 and BCD_MAX_TENS_SEC=4'd5.
//  - Sub-module bcd_mmss_dec (combinational):
//    - in: 16-bit time; out: time-1s and a zero flag.
//    - Instantiated once.
//  - Prescaler counter width = $clog2(TICKS_PER_SEC).
// TESTING (TICKS_PER_SEC=4)
//  1. Entry: keys 1,3,0 in IDLE -> time_bcd=16'h0130; then key 0xA -> unchanged; then key 5 -> 16'h1305.
//  2. Countdown: load 0:02, mag_on=1 held.
//     -> time_bcd 0002 -> 0001 -> 0000 at 4-cycle spacing;
//     -> timer_done high exactly 1 cycle, then state IDLE and running=0.
//  3. Borrow: load 1:00, run one tick -> time_bcd=16'h0059; load 0:90, one tick -> 16'h0089.
//  4. Pause: load 0:03, run 2 cycles, drop mag_on 10 cycles.
//     -> time held at 0003, running=0;
//     -> restore mag_on -> first decrement after 2 more cycles.
//  5. Clear and simultaneous events:
//     - clear_=0 mid-RUN -> time_bcd=0, IDLE, no timer_done;
//     - clear_=0 and digit_valid=1 in the same cycle -> time_bcd=0.
//  6. Reset mid-RUN: reset_=0 asynchronously -> all outputs 0 immediately;
//     mag_on=1 with time 0000 -> stays IDLE, no pulse.

Source files
------------

// File: rtl/cook_timer_pkg.sv
// Purpose: shared types and constants for the cook_timer slice (FSM encoding, BCD limits, MM:SS digit layout).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cook_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Largest value of a units digit and of the tens-of-seconds digit.
  localparam logic [3:0] BCD_MAX_UNIT     = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS_SEC = 4'd5;

  // {m10,m1,s10,s1}, one BCD digit per nibble.
  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } mmss_t;

endpackage

// File: rtl/cook_timer_bcd_mmss_dec.sv
// Purpose: subtract one second from an MM:SS BCD time, with digit borrow; flags a zero result.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: time_in (16b BCD {m10,m1,s10,s1}) -> time_out (time_in - 1s), zero (time_out == 00:00).
module bcd_mmss_dec
  import cook_timer_pkg::*;
(
  input  logic [15:0] time_in,
  output logic [15:0] time_out,
  output logic        zero
);

  mmss_t t_in;
  mmss_t t_out;
  logic  borrow;

  assign t_in = mmss_t'(time_in);

  always_comb begin
    t_out  = t_in;
    borrow = 1'b1;
    // Each digit either absorbs the borrow (nonzero) or wraps to its max and passes it on.
    if (t_in.s1 != 4'd0) begin
      t_out.s1 = t_in.s1 - 4'd1;
      borrow   = 1'b0;
    end else begin
      t_out.s1 = BCD_MAX_UNIT;
    end
    if (borrow) begin
      if (t_in.s10 != 4'd0) begin
        t_out.s10 = t_in.s10 - 4'd1;
        borrow    = 1'b0;
      end else begin
        t_out.s10 = BCD_MAX_TENS_SEC;
      end
    end
    if (borrow) begin
      if (t_in.m1 != 4'd0) begin
        t_out.m1 = t_in.m1 - 4'd1;
        borrow   = 1'b0;
      end else begin
        t_out.m1 = BCD_MAX_UNIT;
      end
    end
    // Caller never decrements 00:00, so m10 cannot underflow in use.
    if (borrow) begin
      t_out.m10 = t_in.m10 - 4'd1;
    end
  end

  assign time_out = 16'(t_out);
  assign zero     = (time_out == 16'h0000);

endmodule

// File: rtl/cook_timer.sv
// Purpose: MM:SS BCD countdown cook timer; keypad entry in IDLE, counts down while mag_on, pulses timer_done at 00:00.
// Latency: all outputs registered; one cycle from a sampled input to its effect on the outputs.
// Backpressure: none; digit_valid is a fire-and-forget strobe, ignored outside IDLE.
// Ports: clk, reset_ (async, low), digit_valid/digit (keypad), clear_ (sync, low), mag_on (run enable)
//        -> time_bcd (16b BCD), running (state RUN), timer_done (one-cycle pulse).
module cook_timer
  import cook_timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        clear_,
  input  logic        mag_on,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        timer_done
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  state_e        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          run_q, run_d;

  logic [15:0]   time_dec;
  logic          dec_zero;

  bcd_mmss_dec u_dec (
    .time_in  (time_q),
    .time_out (time_dec),
    .zero     (dec_zero)
  );

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (!clear_) begin
      // Clear outranks keypad, mag_on and ticks in the same cycle.
      state_d = IDLE;
      time_d  = 16'h0000;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (digit_valid && (digit <= BCD_MAX_UNIT)) begin
            time_d = {time_q[11:0], digit};
          end
          if (mag_on && (time_q != 16'h0000)) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          // A tick coinciding with mag_on falling is lost: pause wins.
          if (!mag_on) begin
            state_d = PAUSED;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            time_d  = time_dec;
            if (dec_zero) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSED: begin
          // Prescaler keeps its partial second across the pause.
          if (mag_on) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = IDLE;
          time_d  = 16'h0000;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      time_q  <= 16'h0000;
      presc_q <= '0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      run_q   <= run_d;
    end
  end

  assign time_bcd   = time_q;
  assign running    = run_q;
  assign timer_done = done_q;

endmodule
